uparc_lsu: RTL and testbench



---
 rtl/uparc_lsu.sv | 204 ++++++++++++++++++++
 tb/tb_uparc_lsu.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uparc_lsu.sv
// Load/store unit: one aligned CPU data-bus transaction at a time, big-endian lanes,
// right-justified zero-extended load data, alignment and bus/timeout error pulses.
module uparc_lsu #(
   parameter int unsigned BUS_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [1:0]  lsu_cmd,
   input  logic        lsu_rnw,
   output logic [31:0] lsu_rdata,
   output logic        lsu_busy,
   output logic        lsu_err_align,
   output logic        lsu_err_bus,
   output logic [31:0] bus_addr,
   output logic        bus_req,
   output logic        bus_rnw,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_ben,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   input  logic        bus_rdy,
   input  logic        bus_err
);

   localparam logic [1:0] CmdIdle  = 2'b00;
   localparam logic [1:0] CmdByte  = 2'b01;
   localparam logic [1:0] CmdHword = 2'b10;
   localparam logic [1:0] CmdWord  = 2'b11;

   typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_bus_q, err_bus_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        rnw_q, rnw_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  ben_q, ben_d;

   logic cmd_valid;
   logic aligned;
   logic timeout;
   logic done;
   logic fail;

   // Right-justify the addressed lane of a big-endian bus word.
   function automatic logic [31:0] extract(logic [31:0] d, logic [1:0] size, logic [1:0] off);
      logic [31:0] r;
      r = d;
      case (size)
         CmdByte: begin
            case (off)
               2'd0:    r = {24'b0, d[31:24]};
               2'd1:    r = {24'b0, d[23:16]};
               2'd2:    r = {24'b0, d[15:8]};
               default: r = {24'b0, d[7:0]};
            endcase
         end
         CmdHword: r = off[1] ? {16'b0, d[15:0]} : {16'b0, d[31:16]};
         default:  r = d;
      endcase
      return r;
   endfunction

   assign cmd_valid = (lsu_cmd != CmdIdle);

   always_comb begin
      case (lsu_cmd)
         CmdHword: aligned = ~lsu_addr[0];
         CmdWord:  aligned = (lsu_addr[1:0] == 2'b00);
         default:  aligned = 1'b1;
      endcase
   end

   assign timeout = (BUS_TIMEOUT != 0) && (cnt_q == 32'(BUS_TIMEOUT - 1));

   assign lsu_busy      = (state_q != StIdle) || (cmd_valid && aligned);
   assign lsu_err_align = (state_q == StIdle) && cmd_valid && !aligned;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      size_d    = size_q;
      off_d     = off_q;
      rdata_d   = rdata_q;
      err_bus_d = 1'b0;
      addr_d    = addr_q;
      req_d     = req_q;
      rnw_d     = rnw_q;
      wdata_d   = wdata_q;
      ben_d     = ben_q;
      done      = 1'b0;
      fail      = 1'b0;

      case (state_q)
         StIdle: begin
            if (cmd_valid && aligned) begin
               size_d  = lsu_cmd;
               off_d   = lsu_addr[1:0];
               addr_d  = {lsu_addr[31:2], 2'b00};
               rnw_d   = lsu_rnw;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = StCmd;
               case (lsu_cmd)
                  CmdByte: begin
                     wdata_d = {4{lsu_wdata[7:0]}};
                     ben_d   = 4'b1000 >> lsu_addr[1:0];
                  end
                  CmdHword: begin
                     wdata_d = {2{lsu_wdata[15:0]}};
                     ben_d   = lsu_addr[1] ? 4'b0011 : 4'b1100;
                  end
                  default: begin
                     wdata_d = lsu_wdata;
                     ben_d   = 4'b1111;
                  end
               endcase
               if (lsu_rnw) ben_d = 4'b1111;
            end
         end
         StCmd: begin
            if (bus_ack && (bus_rdy || bus_err)) begin
               done = 1'b1;
               fail = bus_err;
            end else if (bus_ack) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = StData;
            end else if (timeout) begin
               done = 1'b1;
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StData: begin
            if (bus_rdy || bus_err) begin
               done = 1'b1;
               fail = bus_err;
            end else if (timeout) begin
               done = 1'b1;
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (done) begin
         state_d = StIdle;
         req_d   = 1'b0;
         if (fail) begin
            err_bus_d = 1'b1;
         end else if (rnw_q) begin
            rdata_d = extract(bus_rdata, size_q, off_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         size_q    <= '0;
         off_q     <= '0;
         rdata_q   <= '0;
         err_bus_q <= 1'b0;
         addr_q    <= '0;
         req_q     <= 1'b0;
         rnw_q     <= 1'b0;
         wdata_q   <= '0;
         ben_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         size_q    <= size_d;
         off_q     <= off_d;
         rdata_q   <= rdata_d;
         err_bus_q <= err_bus_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         rnw_q     <= rnw_d;
         wdata_q   <= wdata_d;
         ben_q     <= ben_d;
      end
   end

   assign lsu_rdata   = rdata_q;
   assign lsu_err_bus = err_bus_q;
   assign bus_addr    = addr_q;
   assign bus_req     = req_q;
   assign bus_rnw     = rnw_q;
   assign bus_wdata   = wdata_q;
   assign bus_ben     = ben_q;

endmodule

// File: tb/tb_uparc_lsu.sv
// Directed bench for uparc_lsu (BUS_TIMEOUT=8): loads, stores, alignment, bus error,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_uparc_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [1:0]  lsu_cmd;
   logic        lsu_rnw;
   logic [31:0] lsu_rdata;
   logic        lsu_busy;
   logic        lsu_err_align;
   logic        lsu_err_bus;
   logic [31:0] bus_addr;
   logic        bus_req;
   logic        bus_rnw;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_ben;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_rdy;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   uparc_lsu #(.BUS_TIMEOUT(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .lsu_addr      (lsu_addr),
      .lsu_wdata     (lsu_wdata),
      .lsu_cmd       (lsu_cmd),
      .lsu_rnw       (lsu_rnw),
      .lsu_rdata     (lsu_rdata),
      .lsu_busy      (lsu_busy),
      .lsu_err_align (lsu_err_align),
      .lsu_err_bus   (lsu_err_bus),
      .bus_addr      (bus_addr),
      .bus_req       (bus_req),
      .bus_rnw       (bus_rnw),
      .bus_wdata     (bus_wdata),
      .bus_ben       (bus_ben),
      .bus_ack       (bus_ack),
      .bus_rdata     (bus_rdata),
      .bus_rdy       (bus_rdy),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; inputs change 1 ns after the edge.
   task automatic next;
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle;
      #2;
   endtask

   task automatic bus_idle;
      bus_ack = 1'b0;
      bus_rdy = 1'b0;
      bus_err = 1'b0;
   endtask

   task automatic issue(input logic [1:0] cmd, input logic rnw, input logic [31:0] addr,
                        input logic [31:0] wdata);
      next;
      lsu_cmd   = cmd;
      lsu_rnw   = rnw;
      lsu_addr  = addr;
      lsu_wdata = wdata;
      settle;
   endtask

   initial begin
      rst       = 1'b1;
      lsu_addr  = '0;
      lsu_wdata = '0;
      lsu_cmd   = 2'b00;
      lsu_rnw   = 1'b0;
      bus_rdata = '0;
      bus_idle;
      next;
      next;
      settle;
      chk("reset_rdata", lsu_rdata, 32'h0);
      chk("reset_busy", {31'b0, lsu_busy}, 32'h0);
      chk("reset_err_bus", {31'b0, lsu_err_bus}, 32'h0);
      chk("reset_req", {31'b0, bus_req}, 32'h0);
      chk("reset_addr", bus_addr, 32'h0);
      chk("reset_wdata", bus_wdata, 32'h0);
      chk("reset_ben", {28'b0, bus_ben}, 32'h0);
      chk("reset_rnw", {31'b0, bus_rnw}, 32'h0);
      next;
      rst = 1'b0;

      // Word load, ack+rdy in cycle 1
      issue(2'b11, 1'b1, 32'h0000_0100, 32'h0);
      chk("wl_c0_busy", {31'b0, lsu_busy}, 32'h1);
      chk("wl_c0_align", {31'b0, lsu_err_align}, 32'h0);
      chk("wl_c0_req", {31'b0, bus_req}, 32'h0);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      settle;
      chk("wl_c1_req", {31'b0, bus_req}, 32'h1);
      chk("wl_c1_busy", {31'b0, lsu_busy}, 32'h1);
      chk("wl_c1_addr", bus_addr, 32'h0000_0100);
      chk("wl_c1_ben", {28'b0, bus_ben}, 32'hF);
      chk("wl_c1_rnw", {31'b0, bus_rnw}, 32'h1);
      next;
      bus_idle;
      settle;
      chk("wl_c2_busy", {31'b0, lsu_busy}, 32'h0);
      chk("wl_c2_rdata", lsu_rdata, 32'hDEAD_BEEF);
      chk("wl_c2_err", {31'b0, lsu_err_bus}, 32'h0);
      chk("wl_c2_req", {31'b0, bus_req}, 32'h0);

      // Byte load at 0x103
      issue(2'b01, 1'b1, 32'h0000_0103, 32'h0);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'h1122_3344;
      settle;
      chk("bl_addr", bus_addr, 32'h0000_0100);
      chk("bl_ben", {28'b0, bus_ben}, 32'hF);
      next;
      bus_idle;
      settle;
      chk("bl_rdata", lsu_rdata, 32'h0000_0044);

      // Byte load at 0x101 (lane [23:16])
      issue(2'b01, 1'b1, 32'h0000_0101, 32'h0);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'h1122_3344;
      settle;
      next;
      bus_idle;
      settle;
      chk("bl1_rdata", lsu_rdata, 32'h0000_0022);

      // Halfword load at 0x102
      issue(2'b10, 1'b1, 32'h0000_0102, 32'h0);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'h1122_3344;
      settle;
      next;
      bus_idle;
      settle;
      chk("hl_rdata", lsu_rdata, 32'h0000_3344);

      // Byte store 0xAB at 0x101, ack delayed 3 cycles
      issue(2'b01, 1'b0, 32'h0000_0101, 32'h1234_56AB);
      chk("bs_c0_busy", {31'b0, lsu_busy}, 32'h1);
      next;
      lsu_cmd = 2'b00;
      settle;
      chk("bs_c1_req", {31'b0, bus_req}, 32'h1);
      chk("bs_c1_wdata", bus_wdata, 32'hABAB_ABAB);
      chk("bs_c1_ben", {28'b0, bus_ben}, 32'h4);
      chk("bs_c1_rnw", {31'b0, bus_rnw}, 32'h0);
      chk("bs_c1_addr", bus_addr, 32'h0000_0100);
      for (int i = 2; i <= 3; i++) begin
         next;
         settle;
         chk("bs_wait_req", {31'b0, bus_req}, 32'h1);
         chk("bs_wait_busy", {31'b0, lsu_busy}, 32'h1);
         chk("bs_wait_addr", bus_addr, 32'h0000_0100);
         chk("bs_wait_wdata", bus_wdata, 32'hABAB_ABAB);
      end
      next;
      bus_ack = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      settle;
      chk("bs_c4_req", {31'b0, bus_req}, 32'h1);
      next;
      bus_idle;
      settle;
      chk("bs_c5_busy", {31'b0, lsu_busy}, 32'h0);
      chk("bs_c5_rdata", lsu_rdata, 32'h0000_3344);
      chk("bs_c5_req", {31'b0, bus_req}, 32'h0);

      // Halfword store at 0x102 with separate ack and rdy
      issue(2'b10, 1'b0, 32'h0000_0102, 32'h5555_BEEF);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1;
      settle;
      chk("hs_wdata", bus_wdata, 32'hBEEF_BEEF);
      chk("hs_ben", {28'b0, bus_ben}, 32'h3);
      next;
      bus_idle;
      settle;
      chk("hs_data_req", {31'b0, bus_req}, 32'h0);
      chk("hs_data_busy", {31'b0, lsu_busy}, 32'h1);
      next;
      bus_rdy = 1'b1;
      settle;
      next;
      bus_idle;
      settle;
      chk("hs_done_busy", {31'b0, lsu_busy}, 32'h0);
      chk("hs_done_rdata", lsu_rdata, 32'h0000_3344);

      // Misaligned word at 0x102 and halfword at 0x101
      issue(2'b11, 1'b1, 32'h0000_0102, 32'h0);
      chk("mw_align", {31'b0, lsu_err_align}, 32'h1);
      chk("mw_busy", {31'b0, lsu_busy}, 32'h0);
      next;
      lsu_cmd = 2'b00;
      settle;
      chk("mw_align_off", {31'b0, lsu_err_align}, 32'h0);
      chk("mw_req", {31'b0, bus_req}, 32'h0);
      chk("mw_busy_after", {31'b0, lsu_busy}, 32'h0);
      issue(2'b10, 1'b0, 32'h0000_0101, 32'h0);
      chk("mh_align", {31'b0, lsu_err_align}, 32'h1);
      chk("mh_busy", {31'b0, lsu_busy}, 32'h0);
      next;
      lsu_cmd = 2'b00;
      settle;
      chk("mh_align_off", {31'b0, lsu_err_align}, 32'h0);
      chk("mh_req", {31'b0, bus_req}, 32'h0);

      // Bus error: ack in cycle 1, err (with rdy) in cycle 4
      issue(2'b11, 1'b1, 32'h0000_0200, 32'h0);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1;
      settle;
      next;
      bus_idle;
      settle;
      chk("be_c2_req", {31'b0, bus_req}, 32'h0);
      chk("be_c2_busy", {31'b0, lsu_busy}, 32'h1);
      next;
      settle;
      chk("be_c3_busy", {31'b0, lsu_busy}, 32'h1);
      next;
      bus_err = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      settle;
      chk("be_c4_errbus", {31'b0, lsu_err_bus}, 32'h0);
      next;
      bus_idle;
      settle;
      chk("be_c5_errbus", {31'b0, lsu_err_bus}, 32'h1);
      chk("be_c5_busy", {31'b0, lsu_busy}, 32'h0);
      chk("be_c5_rdata", lsu_rdata, 32'h0000_3344);
      next;
      settle;
      chk("be_c6_errbus", {31'b0, lsu_err_bus}, 32'h0);

      // Timeout: no ack for 8 CMD cycles
      issue(2'b11, 1'b1, 32'h0000_0300, 32'h0);
      next;
      lsu_cmd = 2'b00;
      settle;
      for (int i = 2; i <= 8; i++) begin
         next;
         settle;
      end
      chk("to_c8_req", {31'b0, bus_req}, 32'h1);
      chk("to_c8_busy", {31'b0, lsu_busy}, 32'h1);
      chk("to_c8_errbus", {31'b0, lsu_err_bus}, 32'h0);
      next;
      settle;
      chk("to_c9_errbus", {31'b0, lsu_err_bus}, 32'h1);
      chk("to_c9_busy", {31'b0, lsu_busy}, 32'h0);
      chk("to_c9_req", {31'b0, bus_req}, 32'h0);
      chk("to_c9_rdata", lsu_rdata, 32'h0000_3344);

      // Reset while in DATA, stray rdy afterwards, then a normal load
      issue(2'b11, 1'b1, 32'h0000_0400, 32'h0);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1;
      settle;
      next;
      bus_idle;
      rst = 1'b1;
      settle;
      next;
      rst = 1'b0;
      bus_rdy = 1'b1; bus_rdata = 32'h0000_0055;
      settle;
      chk("rs_busy", {31'b0, lsu_busy}, 32'h0);
      chk("rs_req", {31'b0, bus_req}, 32'h0);
      next;
      bus_idle;
      settle;
      chk("rs_stray_rdata", lsu_rdata, 32'h0);
      chk("rs_stray_errbus", {31'b0, lsu_err_bus}, 32'h0);
      chk("rs_stray_busy", {31'b0, lsu_busy}, 32'h0);
      issue(2'b11, 1'b1, 32'h0000_0500, 32'h0);
      next;
      lsu_cmd = 2'b00;
      bus_ack = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'hCAFE_F00D;
      settle;
      chk("rs_next_addr", bus_addr, 32'h0000_0500);
      next;
      bus_idle;
      settle;
      chk("rs_next_rdata", lsu_rdata, 32'hCAFE_F00D);
      chk("rs_next_busy", {31'b0, lsu_busy}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
